vec_scale_pipe: RTL and testbench
=================================

# vec_scale_pipe

Pipelined fixed-point vector scaler: multiplies each of `CHANNELS` signed Q-format lanes by one shared signed scalar and writes the vector to a downstream FIFO. It replaces the two-state scaler in the fifo_math group. It reads a first-word-fall-through input FIFO and writes the output FIFO directly. It sustains one vector per cycle, and adds selectable rounding and optional saturation.

## Interface
- `DATA_WIDTH`, 32, width of each lane, scalar and result (signed two's complement)
- `Q_BITS`, 10, fractional bits of all operands and results; 1 ≤ `Q_BITS` < `DATA_WIDTH`
- `CHANNELS`, 3, number of vector lanes
- `clock` in 1: rising-edge clock
- `reset` in 1: reset, asynchronous, active-high
- `x` in `[DATA_WIDTH-1:0]` × `CHANNELS`: input vector lanes, valid while `in_empty`=0
- `a` in `DATA_WIDTH`: scalar, sampled with `x`
- `round_en` in 1: 1 = round-half-up, 0 = truncate (floor); sampled with `x`
- `in_empty` in 1: input FIFO empty
- `in_rd_en` out 1: pops input FIFO; `x`/`a`/`round_en` captured on the same edge
- `out` out `[DATA_WIDTH-1:0]` × `CHANNELS`: result vector, registered
- `out_full` in 1: output FIFO full
- `out_wr_en` out 1: pushes `out` into the output FIFO
- `sat_clr` in 1: clears `sat_flag` (exists only with the macro)
- `sat_flag` out 1: sticky saturation indicator (exists only with the macro)

## Operation
- Three registered stages, each with a valid bit `v1`/`v2`/`v3`:
  - S1: operands plus `round_en`.
  - S2: full products, width `2*DATA_WIDTH` per lane, plus `round_en`.
  - S3: final results, which drive `out`.
- Global stall: `stall = v3 & out_full`. When `stall`=0 all stages advance together: S3←S2, S2←S1, S1←input.
- `in_rd_en = ~in_empty & ~stall`. S1 loads `v1 = in_rd_en`, so bubbles propagate as `v`=0.
- `out_wr_en = v3 & ~out_full`. This is purely combinational from registers and `out_full`; it is never asserted when `out_full`=1.
- S2 computes `p = x[i] * a` as a signed full-precision product; no bits are lost.
- S3 computes `r = (p + (round_en ? 2^(Q_BITS-1) : 0)) >>> Q_BITS`, an arithmetic shift, then narrows `r` to `DATA_WIDTH` per the Configuration section.
- Lanes are independent. All lanes share `a` and `round_en`.
- Order is preserved. No vector is dropped or duplicated under any pattern of `in_empty`/`out_full`.
- Reset (asynchronous, any time):
  - Clears `v1`–`v3`, all data registers, `out` (all lanes 0) and `sat_flag`.
  - Vectors in flight are discarded.
  - `in_rd_en`=0 and `out_wr_en`=0 while reset is high and in the first cycle after release until `in_empty`=0.

## Timing
- Latency: a vector popped on the edge closing cycle N appears on `out` with `out_wr_en`=1 in cycle N+3, provided `out_full`=0 throughout.
- Throughput: 1 vector/cycle with `in_empty`=0 and `out_full`=0 continuously.
- Backpressure:
  - When `out_full` rises with `v3`=1, the whole pipeline freezes.
  - Up to 3 vectors are held; `in_rd_en` goes 0 in the same cycle.
  - When `out_full` falls, `out_wr_en` rises in that same cycle.
- Bubbles are not squeezed during a stall. This costs at most 2 slots of occupancy and never costs data.
- Simultaneous `in_empty`=0 and `out_full`=1 with `v3`=0: the pipeline keeps advancing and filling until `v3`=1.
- `sat_flag`, when present:
  - Set on the edge that loads S3 with any saturated lane, including a lane that is then held stalled.
  - `sat_clr` clears it on the next edge.
  - Set has priority over a simultaneous clear.

## Configuration
- Macro: `VEC_SCALE_SAT_EN`.
- Defined:
  - Any lane with `r` > 2^(DATA_WIDTH-1)-1 becomes 2^(DATA_WIDTH-1)-1.
  - Any lane with `r` < -2^(DATA_WIDTH-1) becomes -2^(DATA_WIDTH-1).
  - Saturation sets `sat_flag`.
  - Ports `sat_clr` and `sat_flag` exist.
- Undefined:
  - The result is the low `DATA_WIDTH` bits of `r` (wrap).
  - Ports `sat_clr` and `sat_flag` are absent.
  - No saturation logic is synthesised.

## Test plan
Defaults throughout: Q10, 32-bit, 3 lanes.
- Basic multiply:
  - Stimulus: `x`={2048, -1024, 0}, `a`=1536, `round_en`=0, one vector.
  - Response: `out`={3072, -1536, 0}, `out_wr_en` for exactly 1 cycle, 3 cycles after `in_rd_en`.
- Rounding:
  - Stimulus: `x`={1, -1, 3}, `a`=512.
  - With `round_en`=0: `out`={0, -1, 1}.
  - With `round_en`=1: `out`={1, 0, 2}.
- Overflow:
  - Stimulus: `x`={0x7FFFFFFF, 0x80000000, 1024}, `a`=2048.
  - With the macro: `out`={0x7FFFFFFF, 0x80000000, 2048}, `sat_flag`=1 until `sat_clr` pulses.
  - Without the macro: `out`={0xFFFFFFFE, 0x00000000, 2048}.
- Streaming:
  - Stimulus: 100 back-to-back random vectors with `out_full`=0.
  - Response: one `out_wr_en` per cycle after the 3-cycle fill, matching a reference model in order.
- Backpressure:
  - Stimulus: 6 queued vectors, `out_full`=1 for cycles 4–9.
  - Response: `in_rd_en` drops while full; `out_wr_en` never overlaps `out_full`; all 6 results arrive in order, none lost.
- Reset mid-stream:
  - Stimulus: assert `reset` with 3 vectors in flight.
  - Response: `out`=0 and `out_wr_en`=0 immediately; no stale vector is written after release; the next vector has normal 3-cycle latency.

Source files
------------

// File: rtl/vec_scale_pipe.sv
// vec_scale_pipe: 3-stage signed fixed-point vector * scalar pipeline.
// Define VEC_SCALE_SAT_EN for result saturation plus sat_flag/sat_clr.
module vec_scale_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int Q_BITS     = 10,
    parameter int CHANNELS   = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0]          a,
    input  logic                           round_en,
    input  logic                           in_empty,
    output logic                           in_rd_en,
    output logic [CHANNELS*DATA_WIDTH-1:0] out,
    input  logic                           out_full,
    output logic                           out_wr_en
`ifdef VEC_SCALE_SAT_EN
    ,
    input  logic                           sat_clr,
    output logic                           sat_flag
`endif
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] HALF = PW'(1) << (Q_BITS - 1);
    localparam logic signed [PW-1:0] ZERO = '0;

    logic                         v1_q, v2_q, v3_q;
    logic                         stall;
    logic signed [DATA_WIDTH-1:0] x_in [CHANNELS];
    logic signed [DATA_WIDTH-1:0] x1_q [CHANNELS];
    logic signed [DATA_WIDTH-1:0] a1_q;
    logic                         rnd1_q, rnd2_q;
    logic signed [PW-1:0]         p2_d [CHANNELS];
    logic signed [PW-1:0]         p2_q [CHANNELS];
    logic signed [PW-1:0]         add;
    logic [DATA_WIDTH-1:0]        o3_d [CHANNELS];
    logic [DATA_WIDTH-1:0]        o3_q [CHANNELS];

`ifdef VEC_SCALE_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic signed [PW-1:0] r_d [CHANNELS];
    logic                 sat_any;
    logic                 sat_q;
`endif

    // Handshakes, lane unpacking, multiply, round/shift and narrowing.
    always_comb begin
        stall     = v3_q & out_full;
        in_rd_en  = ~reset & ~in_empty & ~stall;
        out_wr_en = v3_q & ~out_full;
        add       = rnd2_q ? HALF : ZERO;
        out       = '0;
`ifdef VEC_SCALE_SAT_EN
        sat_any   = 1'b0;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            x_in[i] = x[i*DATA_WIDTH +: DATA_WIDTH];
            p2_d[i] = PW'(x1_q[i]) * PW'(a1_q);
`ifdef VEC_SCALE_SAT_EN
            r_d[i] = (p2_q[i] + add) >>> Q_BITS;
            if (&r_d[i][PW-1:DATA_WIDTH-1] || ~|r_d[i][PW-1:DATA_WIDTH-1]) begin
                o3_d[i] = r_d[i][DATA_WIDTH-1:0];
            end else begin
                sat_any = 1'b1;
                o3_d[i] = r_d[i][PW-1] ? SMIN : SMAX;
            end
`else
            o3_d[i] = DATA_WIDTH'((p2_q[i] + add) >>> Q_BITS);
`endif
            out[i*DATA_WIDTH +: DATA_WIDTH] = o3_q[i];
        end
    end

    // Pipeline registers: all stages advance together unless stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            a1_q   <= '0;
            rnd1_q <= 1'b0;
            rnd2_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                x1_q[i] <= '0;
                p2_q[i] <= '0;
                o3_q[i] <= '0;
            end
        end else if (!stall) begin
            v1_q <= in_rd_en;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_rd_en) begin
                x1_q   <= x_in;
                a1_q   <= a;
                rnd1_q <= round_en;
            end
            if (v1_q) begin
                p2_q   <= p2_d;
                rnd2_q <= rnd1_q;
            end
            if (v2_q) begin
                o3_q <= o3_d;
            end
        end
    end

`ifdef VEC_SCALE_SAT_EN
    // Sticky saturation flag; a new saturation wins over a clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if (!stall && v2_q && sat_any) begin
            sat_q <= 1'b1;
        end else if (sat_clr) begin
            sat_q <= 1'b0;
        end
    end

    assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_vec_scale_pipe.sv
// tb_vec_scale_pipe: scoreboard bench for vec_scale_pipe.
// Models the input FIFO as a queue; results checked in order at out_wr_en.
module tb_vec_scale_pipe;

    typedef struct {
        logic [95:0] x;
        logic [31:0] a;
        logic        rnd;
        logic [95:0] exp;
    } vec_t;

    typedef struct {
        logic [95:0] exp;
        int          cyc;
    } sb_t;

    logic        clock;
    logic        reset;
    logic [95:0] x;
    logic [31:0] a;
    logic        round_en;
    logic        in_empty;
    logic        in_rd_en;
    logic [95:0] out;
    logic        out_full;
    logic        out_wr_en;
`ifdef VEC_SCALE_SAT_EN
    logic        sat_clr;
    logic        sat_flag;
`endif

    vec_scale_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .x         (x),
        .a         (a),
        .round_en  (round_en),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out       (out),
        .out_full  (out_full),
        .out_wr_en (out_wr_en)
`ifdef VEC_SCALE_SAT_EN
        ,
        .sat_clr   (sat_clr),
        .sat_flag  (sat_flag)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    vec_t inq[$];
    sb_t  sb[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;
    int   nwr    = 0;
    int   first_wr = -1;
    int   last_wr  = -1;
    bit   lat_chk  = 1'b1;
    logic s_rd, s_wr;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [95:0] pack3(input int l0, input int l1, input int l2);
        return {32'(l2), 32'(l1), 32'(l0)};
    endfunction

    function automatic logic [95:0] model(input logic [95:0] xv,
                                          input logic [31:0] av, input logic rnd);
        logic [95:0] o;
        longint      p;
        o = '0;
        for (int i = 0; i < 3; i++) begin
            p = longint'($signed(xv[i*32 +: 32])) * longint'($signed(av));
            if (rnd) p = p + 512;
            p = p >>> 10;
`ifdef VEC_SCALE_SAT_EN
            if (p > 64'sh7FFFFFFF) p = 64'sh7FFFFFFF;
            else if (p < -64'sh80000000) p = -64'sh80000000;
`endif
            o[i*32 +: 32] = p[31:0];
        end
        return o;
    endfunction

    task automatic drive();
        in_empty = (inq.size() == 0);
        if (inq.size() != 0) begin
            x        = inq[0].x;
            a        = inq[0].a;
            round_en = inq[0].rnd;
        end
    endtask

    task automatic push(input logic [95:0] xv, input logic [31:0] av,
                        input logic rnd, input logic [95:0] ev);
        inq.push_back('{xv, av, rnd, ev});
        drive();
    endtask

    task automatic step();
        sb_t  e;
        vec_t v;
        @(negedge clock);
        s_rd = in_rd_en;
        s_wr = out_wr_en;
        if (out_full) check("wr_while_full", out_wr_en, 0);
        if (out_wr_en) begin
            nwr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            check("sb_nonempty_on_wr", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data", out, e.exp);
                if (lat_chk) check("latency", cyc - e.cyc, 3);
            end
        end
        @(posedge clock);
        #1;
        if (s_rd && inq.size() != 0) begin
            v = inq.pop_front();
            sb.push_back('{v.exp, cyc});
        end
        cyc++;
        drive();
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while ((inq.size() != 0 || sb.size() != 0) && n < lim) begin
            step();
            n++;
        end
        check("drain_done", sb.size() + inq.size(), 0);
    endtask

    initial begin
        int n0;
        logic [95:0] xv;
        logic [31:0] av;
        logic        rv;

        reset    = 1'b0;
        x        = '0;
        a        = '0;
        round_en = 1'b0;
        in_empty = 1'b1;
        out_full = 1'b0;
`ifdef VEC_SCALE_SAT_EN
        sat_clr  = 1'b0;
`endif
        #2 reset = 1'b1;
        #1;
        check("rst_out", out, 0);
        check("rst_wr", out_wr_en, 0);

        // Basic multiply, queued during reset: no pop while reset is high.
        push(pack3(2048, -1024, 0), 32'd1536, 1'b0, pack3(3072, -1536, 0));
        step();
        check("rst_rd", s_rd, 0);
        step();
        check("rst_rd2", s_rd, 0);
`ifdef VEC_SCALE_SAT_EN
        check("rst_sat", sat_flag, 0);
`endif
        reset = 1'b0;
        n0 = nwr;
        drain(20);
        repeat (3) step();
        check("basic_wr_count", nwr - n0, 1);

        // Rounding: truncate then round-half-up.
        push(pack3(1, -1, 3), 32'd512, 1'b0, pack3(0, -1, 1));
        push(pack3(1, -1, 3), 32'd512, 1'b1, pack3(1, 0, 2));
        drain(20);

        // Overflow: saturate or wrap depending on build.
`ifdef VEC_SCALE_SAT_EN
        push({32'd1024, 32'h80000000, 32'h7FFFFFFF}, 32'd2048, 1'b0,
             {32'd2048, 32'h80000000, 32'h7FFFFFFF});
`else
        push({32'd1024, 32'h80000000, 32'h7FFFFFFF}, 32'd2048, 1'b0,
             {32'd2048, 32'h00000000, 32'hFFFFFFFE});
`endif
        drain(20);
`ifdef VEC_SCALE_SAT_EN
        check("sat_set", sat_flag, 1);
        repeat (2) step();
        check("sat_sticky", sat_flag, 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check("sat_clr", sat_flag, 0);
`endif

        // Streaming: 100 back-to-back random vectors.
        for (int i = 0; i < 100; i++) begin
            xv = {$urandom(), $urandom(), $urandom()};
            if (i % 4 == 0) av = $urandom();
            else av = 32'($urandom_range(0, 8191)) - 32'd4096;
            rv = 1'($urandom_range(0, 1));
            if (i % 3 == 0) xv = pack3(int'($urandom_range(0, 200000)) - 100000,
                                       int'($urandom_range(0, 2000)) - 1000, 511);
            push(xv, av, rv, model(xv, av, rv));
        end
        n0 = nwr;
        first_wr = -1;
        drain(200);
        check("stream_count", nwr - n0, 100);
        check("stream_gap", last_wr - first_wr, 99);

        // Backpressure: 6 vectors, out_full high for cycles 4..9.
        lat_chk = 1'b0;
        for (int i = 0; i < 6; i++) begin
            xv = pack3(i * 1000 + 7, -i * 333 - 1, i << 20);
            av = 32'(i * 700 + 300);
            rv = i[0];
            push(xv, av, rv, model(xv, av, rv));
        end
        n0 = nwr;
        for (int k = 0; k < 30; k++) begin
            out_full = (k >= 4 && k <= 9);
            step();
            if (k >= 4 && k <= 9) check("rd_during_full", s_rd, 0);
            if (k == 10) check("wr_on_release", s_wr, 1);
        end
        out_full = 1'b0;
        check("bp_count", nwr - n0, 6);
        check("bp_drained", sb.size() + inq.size(), 0);
        lat_chk = 1'b1;

        // Reset with three vectors in flight.
        for (int i = 0; i < 3; i++) begin
            xv = pack3(i + 5, i + 6, i + 7);
            push(xv, 32'd1024, 1'b0, model(xv, 32'd1024, 1'b0));
        end
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out", out, 0);
        check("mid_rst_wr", out_wr_en, 0);
        sb.delete();
        inq.delete();
        drive();
        repeat (2) step();
        reset = 1'b0;
        n0 = nwr;
        repeat (5) step();
        check("no_stale", nwr - n0, 0);
        push(pack3(-4096, 4096, 100), 32'd3072, 1'b1, pack3(-12288, 12288, 300));
        drain(20);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
